// File: rtl/branch_cmp_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_cmp_ctrl_if
//   Bundles every non-clock/reset signal of the ID-stage branch compare
//   controller: the branch request from ID, hazard/forwarding information
//   from EX and MEM, the Comparator operand/result pair, and the PC-redirect,
//   stall and counter outputs.
//
//   master : pipeline side (ID/EX/MEM stages, Comparator, IF PC mux)
//   slave  : branch_cmp_ctrl
// ---------------------------------------------------------------------------
interface branch_cmp_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  // ID-stage branch request
  logic              id_kill;
  logic              br_valid;
  logic              br_is_bne;
  logic [REG_AW-1:0] br_rs;
  logic [REG_AW-1:0] br_rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] br_target;
  // EX / MEM hazard and forwarding sources
  logic              ex_wr_en;
  logic [REG_AW-1:0] ex_wr_reg;
  logic              mem_wr_en;
  logic [REG_AW-1:0] mem_wr_reg;
  logic              mem_is_load;
  logic [DATA_W-1:0] mem_alu_data;
  // Comparator
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_r;
  // Pipeline control and statistics
  logic              stall;
  logic              redirect;
  logic [DATA_W-1:0] pc_target;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_kill, br_valid, br_is_bne, br_rs, br_rt, rs_data, rt_data,
           br_target, ex_wr_en, ex_wr_reg, mem_wr_en, mem_wr_reg,
           mem_is_load, mem_alu_data, cmp_r,
    input  cmp_a, cmp_b, stall, redirect, pc_target, br_cnt, stall_cnt
  );

  modport slave (
    input  id_kill, br_valid, br_is_bne, br_rs, br_rt, rs_data, rt_data,
           br_target, ex_wr_en, ex_wr_reg, mem_wr_en, mem_wr_reg,
           mem_is_load, mem_alu_data, cmp_r,
    output cmp_a, cmp_b, stall, redirect, pc_target, br_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// branch_cmp_ctrl
//   Sequences the shared 16-bit equality Comparator for BEQ/BNE resolution in
//   ID. A branch whose operands are still being produced by an EX instruction
//   (any kind) or by a load in MEM is held in WAIT with ID stalled. Once the
//   operands are available (register file write-through or the MEM ALU
//   forward path) they are registered into the Comparator and the branch is
//   resolved one cycle later, pulsing redirect when taken.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_cmp_ctrl_if.slave
//            in : id_kill, br_valid, br_is_bne, br_rs, br_rt, rs_data,
//                 rt_data, br_target, ex_wr_en, ex_wr_reg, mem_wr_en,
//                 mem_wr_reg, mem_is_load, mem_alu_data, cmp_r
//            out: cmp_a, cmp_b (registered Comparator operands), stall,
//                 redirect (one-cycle pulse), pc_target (registered),
//                 br_cnt, stall_cnt (saturating counters)
// ---------------------------------------------------------------------------
module branch_cmp_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  branch_cmp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t            state;
  logic              bne_flag_p0;
  logic [DATA_W-1:0] cmp_a_p0;
  logic [DATA_W-1:0] cmp_b_p0;
  logic [DATA_W-1:0] pc_target_p0;
  logic [CNT_W-1:0]  br_cnt_p0;
  logic [CNT_W-1:0]  stall_cnt_p0;

  logic              hazard;
  logic              take;
  logic              stall_c;
  logic              redirect_c;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Register index x is a live source of the branch (r0 never is).
  function automatic logic src_match(input logic [REG_AW-1:0] x,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
    return (x != '0) && ((x == rs) || (x == rt));
  endfunction

  // MEM ALU results bypass the register file; loads are not forwarded since
  // their data only appears at WB.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] idx,
                                                input logic [DATA_W-1:0] rf_val,
                                                input logic              m_en,
                                                input logic              m_load,
                                                input logic [REG_AW-1:0] m_reg,
                                                input logic [DATA_W-1:0] m_val);
    if (m_en && !m_load && (idx != '0) && (idx == m_reg)) return m_val;
    return rf_val;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage p0 inputs: hazard detection, operand selection, handshake outputs
  always_comb begin
    hazard = (bus.ex_wr_en && src_match(bus.ex_wr_reg, bus.br_rs, bus.br_rt)) ||
             (bus.mem_wr_en && bus.mem_is_load &&
              src_match(bus.mem_wr_reg, bus.br_rs, bus.br_rt));

    fwd_a = fwd_sel(bus.br_rs, bus.rs_data, bus.mem_wr_en, bus.mem_is_load,
                    bus.mem_wr_reg, bus.mem_alu_data);
    fwd_b = fwd_sel(bus.br_rt, bus.rt_data, bus.mem_wr_en, bus.mem_is_load,
                    bus.mem_wr_reg, bus.mem_alu_data);

    // Operands are captured on the cycle a waiting or newly arrived branch
    // becomes hazard-free.
    take = !bus.id_kill && bus.br_valid && !hazard &&
           ((state == IDLE) || (state == WAIT));

    // rst_n gates both outputs so they drop the instant reset asserts.
    stall_c    = rst_n && bus.br_valid && !bus.id_kill && (state != RESOLVE);
    redirect_c = rst_n && !bus.id_kill && (state == RESOLVE) &&
                 (bus.cmp_r ^ bne_flag_p0);
  end

  // Stage p0 -> p1: FSM, operand/target capture, statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bne_flag_p0  <= 1'b0;
      cmp_a_p0     <= '0;
      cmp_b_p0     <= '0;
      pc_target_p0 <= '0;
      br_cnt_p0    <= '0;
      stall_cnt_p0 <= '0;
    end else begin
      if (stall_c) stall_cnt_p0 <= sat_inc(stall_cnt_p0);

      if (take) begin
        cmp_a_p0     <= fwd_a;
        cmp_b_p0     <= fwd_b;
        pc_target_p0 <= bus.br_target;
        bne_flag_p0  <= bus.br_is_bne;
      end

      if (bus.id_kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.br_valid) state <= hazard ? WAIT : RESOLVE;
          end
          WAIT: begin
            // A branch vanishing without a kill is abandoned quietly.
            if (!bus.br_valid)  state <= IDLE;
            else if (!hazard)   state <= RESOLVE;
          end
          RESOLVE: begin
            br_cnt_p0 <= sat_inc(br_cnt_p0);
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmp_a     = cmp_a_p0;
  assign bus.cmp_b     = cmp_b_p0;
  assign bus.pc_target = pc_target_p0;
  assign bus.br_cnt    = br_cnt_p0;
  assign bus.stall_cnt = stall_cnt_p0;
  assign bus.stall     = stall_c;
  assign bus.redirect  = redirect_c;

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_cmp_ctrl
//   Drives the branch controller from a tiny pipeline environment (register
//   file, EX and MEM slots, equality Comparator). Expected operands are the
//   architectural register values in program order, expected stall lengths
//   follow from which older instruction produces an operand, and counters
//   are tracked as plain integers.
// ---------------------------------------------------------------------------
module tb_branch_cmp_ctrl;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_cmp_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  branch_cmp_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared equality Comparator
  assign bus.cmp_r = (bus.cmp_a == bus.cmp_b);

  typedef struct packed {
    logic              wr_en;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic [DATA_W-1:0] val;
  } slot_t;

  logic [DATA_W-1:0] rf [8];
  slot_t             ex_s, mem_s;
  logic [DATA_W-1:0] junk;
  logic              bne;
  logic [REG_AW-1:0] rs, rt;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] last_a, last_b, last_pc;

  int          checks = 0;
  int          failures = 0;
  int unsigned br_cnt_m = 0;
  int unsigned stall_cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned x);
    return (x > 32'hFFFF) ? 32'hFFFF : x;
  endfunction

  task automatic drive();
    bus.br_rs        = rs;
    bus.br_rt        = rt;
    bus.rs_data      = rf[rs];
    bus.rt_data      = rf[rt];
    bus.br_is_bne    = bne;
    bus.br_target    = target;
    bus.ex_wr_en     = ex_s.wr_en;
    bus.ex_wr_reg    = ex_s.rd;
    bus.mem_wr_en    = mem_s.wr_en;
    bus.mem_wr_reg   = mem_s.rd;
    bus.mem_is_load  = mem_s.is_load;
    bus.mem_alu_data = mem_s.is_load ? junk : mem_s.val;
  endtask

  // One stalled cycle: MEM retires into the register file, EX moves to MEM,
  // a bubble enters EX.
  task automatic advance();
    if (mem_s.wr_en && mem_s.rd != 0) rf[mem_s.rd] = mem_s.val;
    mem_s = ex_s;
    ex_s  = '0;
    drive();
  endtask

  // Program-order value of a register as seen by the branch.
  function automatic logic [DATA_W-1:0] arch_val(input logic [REG_AW-1:0] idx);
    logic [DATA_W-1:0] v;
    if (idx == 0) return '0;
    v = rf[idx];
    if (mem_s.wr_en && mem_s.rd == idx) v = mem_s.val;
    if (ex_s.wr_en && ex_s.rd == idx) v = ex_s.val;
    return v;
  endfunction

  function automatic logic produces(input slot_t s);
    return s.wr_en && (s.rd != 0) && (s.rd == rs || s.rd == rt);
  endfunction

  // Cycles until the operand value is visible to ID (regfile or forward).
  function automatic int exp_stalls();
    if (produces(ex_s) && ex_s.is_load) return 3;
    if (produces(ex_s)) return 2;
    if (produces(mem_s) && mem_s.is_load) return 2;
    return 1;
  endfunction

  function automatic logic [DATA_W-1:0] pick_val();
    case ($urandom_range(0, 3))
      0: return 16'h1234;
      1: return 16'h00FF;
      2: return 16'hBEEF;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.wr_en   = 1'($urandom_range(0, 1));
    s.rd      = REG_AW'($urandom_range(0, 7));
    s.is_load = 1'($urandom_range(0, 1));
    s.val     = pick_val();
    return s;
  endfunction

  task automatic rand_ctx();
    for (int i = 1; i < 8; i++) rf[i] = pick_val();
    rs     = REG_AW'($urandom_range(0, 7));
    rt     = REG_AW'($urandom_range(0, 7));
    bne    = 1'($urandom_range(0, 1));
    target = DATA_W'($urandom);
    junk   = DATA_W'($urandom);
    ex_s   = rand_slot();
    mem_s  = rand_slot();
  endtask

  task automatic clear_ctx();
    for (int i = 0; i < 8; i++) rf[i] = '0;
    ex_s  = '0;
    mem_s = '0;
    junk  = 16'hDEAD;
  endtask

  // Present the branch in rs/rt/bne/target with the current EX/MEM contents
  // and follow it to resolution.
  task automatic run_branch(input string tag);
    logic [DATA_W-1:0] ea, eb;
    logic              etaken;
    int                est, stalls;
    logic              done;
    ea     = arch_val(rs);
    eb     = arch_val(rt);
    etaken = (ea == eb) ^ bne;
    est    = exp_stalls();
    stalls = 0;
    done   = 1'b0;
    bus.br_valid = 1'b1;
    drive();
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (bus.stall) begin
        check({tag, "_redirect_in_stall"}, 32'(bus.redirect), 32'd0);
        stalls++;
        stall_cnt_m++;
        @(posedge clk); #1;
        advance();
      end else begin
        check({tag, "_stalls"}, 32'(stalls), 32'(est));
        check({tag, "_redirect"}, 32'(bus.redirect), 32'(etaken));
        check({tag, "_cmp_a"}, 32'(bus.cmp_a), 32'(ea));
        check({tag, "_cmp_b"}, 32'(bus.cmp_b), 32'(eb));
        check({tag, "_pc_target"}, 32'(bus.pc_target), 32'(target));
        br_cnt_m++;
        done = 1'b1;
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        check({tag, "_br_cnt"}, 32'(bus.br_cnt), sat(br_cnt_m));
        check({tag, "_stall_cnt"}, 32'(bus.stall_cnt), sat(stall_cnt_m));
      end
    end
    if (!done) begin
      check({tag, "_budget"}, 32'(stalls), 32'(est));
      bus.br_valid = 1'b0;
    end
    last_a  = ea;
    last_b  = eb;
    last_pc = target;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with a branch request present to show stall stays low
    clear_ctx();
    rs = 3'd1; rt = 3'd2; bne = 1'b0; target = '0;
    bus.id_kill  = 1'b0;
    bus.br_valid = 1'b1;
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_redirect", 32'(bus.redirect), 32'd0);
    check("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
    check("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
    check("rst_pc_target", 32'(bus.pc_target), 32'd0);
    check("rst_br_cnt", 32'(bus.br_cnt), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    bus.br_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BEQ equal operands, no hazards
    clear_ctx();
    rf[1] = 16'h1234; rf[2] = 16'h1234;
    rs = 3'd1; rt = 3'd2; bne = 1'b0; target = 16'h0040;
    run_branch("beq_eq");

    // BNE equal (not taken) then BNE different (taken), back to back
    clear_ctx();
    rf[1] = 16'd5; rf[2] = 16'd5; bne = 1'b1; target = 16'h0080;
    run_branch("bne_eq");
    rf[1] = 16'd7; rf[2] = 16'd3; target = 16'h00C0;
    run_branch("bne_ne");

    // EX ALU producer of r1, forwarded from MEM one cycle later
    clear_ctx();
    rf[1] = 16'h0000; rf[2] = 16'h00FF; bne = 1'b0; target = 16'h0100;
    ex_s = '{wr_en: 1'b1, rd: 3'd1, is_load: 1'b0, val: 16'h00FF};
    run_branch("ex_alu");

    // EX load producer of r2
    clear_ctx();
    rf[1] = 16'h0042; rf[2] = 16'h0000; target = 16'h0140;
    ex_s = '{wr_en: 1'b1, rd: 3'd2, is_load: 1'b1, val: 16'h0042};
    run_branch("ex_load");

    // r0 operand with an EX write to r0: no hazard
    clear_ctx();
    rs = 3'd0; rt = 3'd0; target = 16'h0180;
    ex_s = '{wr_en: 1'b1, rd: 3'd0, is_load: 1'b1, val: 16'h5555};
    run_branch("r0_nohaz");

    // Kill while waiting on a load
    clear_ctx();
    rs = 3'd1; rt = 3'd2; bne = 1'b0; target = 16'h0FFF;
    ex_s = '{wr_en: 1'b1, rd: 3'd2, is_load: 1'b1, val: 16'h0001};
    bus.br_valid = 1'b1;
    drive();
    @(negedge clk);
    check("kill_first_stall", 32'(bus.stall), 32'd1);
    stall_cnt_m++;
    @(posedge clk); #1;
    advance();
    bus.id_kill = 1'b1;
    @(negedge clk);
    check("kill_stall", 32'(bus.stall), 32'd0);
    check("kill_redirect", 32'(bus.redirect), 32'd0);
    @(posedge clk); #1;
    bus.id_kill  = 1'b0;
    bus.br_valid = 1'b0;
    check("kill_br_cnt", 32'(bus.br_cnt), sat(br_cnt_m));
    check("kill_stall_cnt", 32'(bus.stall_cnt), sat(stall_cnt_m));
    check("kill_cmp_a_hold", 32'(bus.cmp_a), 32'(last_a));
    check("kill_pc_hold", 32'(bus.pc_target), 32'(last_pc));
    @(negedge clk);
    check("kill_idle_stall", 32'(bus.stall), 32'd0);
    check("kill_idle_redirect", 32'(bus.redirect), 32'd0);
    @(posedge clk); #1;

    // Randomized branches with occasional idle gaps
    for (int n = 0; n < 300; n++) begin
      rand_ctx();
      run_branch("rand");
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check("gap_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
      end
    end

    // Async reset while in RESOLVE of a taken branch
    clear_ctx();
    rf[1] = 16'hAAAA; rf[2] = 16'hAAAA; rs = 3'd1; rt = 3'd2;
    bne = 1'b0; target = 16'h0200;
    bus.br_valid = 1'b1;
    drive();
    @(negedge clk);
    check("rr_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rr_redirect", 32'(bus.redirect), 32'd0);
    check("rr_stall_rst", 32'(bus.stall), 32'd0);
    check("rr_cmp_a", 32'(bus.cmp_a), 32'd0);
    check("rr_pc_target", 32'(bus.pc_target), 32'd0);
    check("rr_br_cnt", 32'(bus.br_cnt), 32'd0);
    check("rr_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    br_cnt_m = 0;
    stall_cnt_m = 0;
    @(negedge clk);
    check("rr_hold_redirect", 32'(bus.redirect), 32'd0);
    check("rr_hold_stall", 32'(bus.stall), 32'd0);
    bus.br_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rr_after_br_cnt", 32'(bus.br_cnt), 32'd0);

    // Long stall to saturate stall_cnt
    clear_ctx();
    rs = 3'd1; rt = 3'd2;
    ex_s = '{wr_en: 1'b1, rd: 3'd1, is_load: 1'b0, val: 16'h0001};
    bus.br_valid = 1'b1;
    drive();
    repeat (65600) @(posedge clk);
    stall_cnt_m += 65600;
    #1;
    check("sat_stall_cnt", 32'(bus.stall_cnt), sat(stall_cnt_m));
    check("sat_still_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    stall_cnt_m++;
    check("sat_no_wrap", 32'(bus.stall_cnt), sat(stall_cnt_m));
    bus.id_kill = 1'b1;
    @(posedge clk); #1;
    bus.id_kill  = 1'b0;
    bus.br_valid = 1'b0;
    check("sat_br_cnt", 32'(bus.br_cnt), sat(br_cnt_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
